// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode constants,
// FSM state encoding and the operand-usage decode helpers.
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JV    = 6'b000011;
    localparam logic [5:0] OP_IN    = 6'b100100;
    localparam logic [5:0] OP_OUT   = 6'b101100;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_HALT  = 2'b10,
        ST_TRAP  = 2'b11
    } state_t;

    // Jumps and HLT carry no rs source operand.
    function automatic logic op_uses_rs(input logic [5:0] op);
        case (op)
            OP_J, OP_JV, OP_HLT: return 1'b0;
            default:             return 1'b1;
        endcase
    endfunction

    // rt is a source only for R-type, branches, stores and OUT.
    function automatic logic op_uses_rt(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_OUT: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// load_use_detect: combinational load-use hazard detector.
// Ports:
//   i_op, i_rs, i_rt : opcode and source fields of the instruction in ID
//   i_ex_memr        : instruction in EX reads memory (lw / IN)
//   i_ex_rt          : destination register of the instruction in EX
//   o_load_use       : ID instruction needs a value not yet loaded
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_ex_memr,
    input  logic [4:0] i_ex_rt,
    output logic       o_load_use
);

    // Compare the EX load destination against the ID sources actually read; $0 never hazards.
    always_comb begin
        o_load_use = 1'b0;
        if (i_ex_memr && (i_ex_rt != 5'd0)) begin
            if ((op_uses_rs(i_op) && (i_rs == i_ex_rt)) ||
                (op_uses_rt(i_op) && (i_rt == i_ex_rt))) begin
                o_load_use = 1'b1;
            end else begin
                o_load_use = 1'b0;
            end
        end else begin
            o_load_use = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard / control FSM (RUN, FLUSH, HALT, TRAP).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_inst, id_undef   : instruction in IF/ID and its undefined-opcode flag
//   ex_memr, ex_rt      : load in EX and its destination register
//   ex_branch_taken     : branch resolved taken in EX
//   resume              : pulse releasing HALT
//   pipe_stall, pc_write_en, ifid_write_en, ifid_flush : pipeline controls
//   halted, trap        : status flags
//   stall_cycles        : saturating count of stall cycles in RUN/FLUSH
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             id_undef,
    input  logic             ex_memr,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             resume,
    output logic             pipe_stall,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] BUBBLE_INIT = 2'(BRANCH_PENALTY - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_bubble;
    logic [1:0]       w_bubble_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;
    logic             w_stall;
    logic             w_pc_we;
    logic             w_ifid_we;
    logic             w_flush;
    logic             w_count_en;
    logic [5:0]       w_op;
    logic             w_unused_bits;

    assign w_op          = id_inst[31:26];
    assign w_unused_bits = ^id_inst[15:0];

    load_use_detect u_load_use (
        .i_op       (w_op),
        .i_rs       (id_inst[25:21]),
        .i_rt       (id_inst[20:16]),
        .i_ex_memr  (ex_memr),
        .i_ex_rt    (ex_rt),
        .o_load_use (w_load_use)
    );

    // State and bubble-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_bubble <= 2'd0;
        end else begin
            r_state  <= w_next_state;
            r_bubble <= w_bubble_next;
        end
    end

    // Next-state and control decode; priority branch > load-use > undef > HLT.
    always_comb begin
        w_next_state  = r_state;
        w_bubble_next = r_bubble;
        w_stall       = 1'b0;
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_flush       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    w_stall       = 1'b1;
                    w_flush       = 1'b1;
                    w_next_state  = ST_FLUSH;
                    w_bubble_next = BUBBLE_INIT;
                end else if (w_load_use) begin
                    w_stall   = 1'b1;
                    w_pc_we   = 1'b0;
                    w_ifid_we = 1'b0;
                end else if (id_undef) begin
                    w_next_state = ST_TRAP;
                end else if (w_op == OP_HLT) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_stall = 1'b1;
                w_flush = 1'b1;
                if (r_bubble == 2'd0) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_bubble_next = r_bubble - 2'd1;
                end
            end
            ST_HALT: begin
                w_stall   = 1'b1;
                w_pc_we   = 1'b0;
                w_ifid_we = 1'b0;
                if (resume) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            ST_TRAP: begin
                w_stall   = 1'b1;
                w_pc_we   = 1'b0;
                w_ifid_we = 1'b0;
            end
            default: begin
                w_next_state  = ST_RUN;
                w_bubble_next = 2'd0;
            end
        endcase
    end

    // Outputs are forced to idle RUN values while reset is held, whatever the inputs.
    always_comb begin
        if (rst) begin
            pipe_stall    = 1'b0;
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            ifid_flush    = 1'b0;
        end else begin
            pipe_stall    = w_stall;
            pc_write_en   = w_pc_we;
            ifid_write_en = w_ifid_we;
            ifid_flush    = w_flush;
        end
    end

    assign halted     = (r_state == ST_HALT);
    assign trap       = (r_state == ST_TRAP);
    assign w_count_en = w_stall && ((r_state == ST_RUN) || (r_state == ST_FLUSH));

    // Saturating stall-cycle counter; HALT and TRAP cycles are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_count_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter BRANCH_PENALTY, default 1, legal range 1..3: bubble cycles inserted after a taken branch.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_inst  in  32  instruction currently held in the IF/ID register.
REQ-006 id_undef  in  1  UndefInst from the ID-stage decoder.
REQ-007 ex_memr  in  1  MemR of the instruction in EX (lw or IN).
REQ-008 ex_rt  in  5  destination register (rt) of the instruction in EX.
REQ-009 ex_branch_taken  in  1  beq/bne resolved taken in EX this cycle.
REQ-010 resume  in  1  one-cycle pulse that releases the HALT state.
REQ-011 pipe_stall  out  1  drives the decoder Pipe_stall input and zeroes ID control signals.
REQ-012 pc_write_en  out  1  PC update enable.
REQ-013 ifid_write_en  out  1  IF/ID register load enable.
REQ-014 ifid_flush  out  1  clears IF/ID to a NOP.
REQ-015 halted  out  1  core stopped by HLT.
REQ-016 trap  out  1  sticky flag: undefined instruction reached ID.
REQ-017 stall_cycles  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 SHALL implement the FSM states RUN, FLUSH, HALT and TRAP.
REQ-019 Opcode fields: op = id_inst[31:26], rs = id_inst[25:21], rt = id_inst[20:16].
REQ-020 "uses_rs" SHALL be 1 for every opcode except 000010, 000011 and 111111.
REQ-021 "uses_rt" SHALL be 1 only for opcodes 000000, 000100, 000101, 101011 and 101100.
REQ-022 Load-use condition: ex_memr=1, ex_rt!=0, and either (uses_rs and rs==ex_rt) or (uses_rt and rt==ex_rt).
REQ-023 In RUN, a load-use condition SHALL give, in the same cycle (combinational): pipe_stall=1, pc_write_en=0, ifid_write_en=0, ifid_flush=0; the state stays RUN.
REQ-024 In RUN, ex_branch_taken=1 SHALL give, in the same cycle: ifid_flush=1, pipe_stall=1, pc_write_en=1; the next state is FLUSH with the bubble counter set to BRANCH_PENALTY-1.
REQ-025 Each FLUSH cycle SHALL give: pipe_stall=1, ifid_flush=1, pc_write_en=1, ifid_write_en=1.
REQ-026 FLUSH SHALL decrement the bubble counter each cycle and return to RUN after the cycle in which the counter is 0.
REQ-027 With BRANCH_PENALTY=1, FLUSH therefore lasts exactly one cycle.
REQ-028 In RUN with no branch and no load-use, op==111111 SHALL move the FSM to HALT on the next edge.
REQ-029 In RUN with no branch and no load-use, id_undef=1 SHALL move the FSM to TRAP on the next edge.
REQ-030 The cycle that detects HLT or undef SHALL drive the normal RUN outputs.
REQ-031 Priority SHALL be ex_branch_taken > load-use > undef > HLT; a wrong-path HLT or undef in ID is discarded when a branch is taken.
REQ-032 HALT and TRAP SHALL drive pipe_stall=1, pc_write_en=0, ifid_write_en=0 and ifid_flush=0.
REQ-033 HALT SHALL drive halted=1; resume=1 in HALT SHALL return the FSM to RUN on the next edge; resume is ignored in every other state.
REQ-034 TRAP SHALL drive trap=1 and SHALL be left only by rst.
REQ-035 In RUN with no hazard: pipe_stall=0, pc_write_en=1, ifid_write_en=1, ifid_flush=0.
REQ-036 stall_cycles SHALL increment on every edge where pipe_stall=1 in RUN or FLUSH, and SHALL saturate at all-ones.
REQ-037 stall_cycles SHALL NOT count cycles spent in HALT or TRAP.

Reset
REQ-038 rst=1 SHALL asynchronously force: state RUN, bubble counter 0, stall_cycles 0, halted 0, trap 0.
REQ-039 While rst=1, outputs SHALL be the idle RUN values: pipe_stall 0, pc_write_en 1, ifid_write_en 1, ifid_flush 0.
REQ-040 Reset asserted during FLUSH, HALT or TRAP SHALL abandon the state with no residual bubbles.

Structure
REQ-041 The shared package SHALL hold the opcode constants (RTYPE 000000, BEQ 000100, BNE 000101, LW 100011, SW 101011, J 000010, JV 000011, IN 100100, OUT 101100, HLT 111111) and the FSM state encoding.
REQ-042 Combinational hazard detection SHALL be a sub-module, load_use_detect.

Verification
REQ-043 lw writing $5 in EX, then `add $6,$5,$7` in ID (rs=5) -> one cycle with pipe_stall=1 and pc_write_en=0; stall_cycles=1.
REQ-044 EX holds a load with ex_rt=0, ID holds an instruction using rs=0 -> no stall.
REQ-045 ex_branch_taken=1 with BRANCH_PENALTY=2 -> ifid_flush high for 3 consecutive cycles, then RUN; stall_cycles=3.
REQ-046 HLT (0xFC000000) in ID -> halted=1 from the next cycle; counter frozen; resume pulse -> RUN with pc_write_en=1.
REQ-047 id_undef=1 together with ex_branch_taken=1 -> FLUSH, not TRAP; id_undef=1 alone -> trap=1 persists until rst.
REQ-048 stall_cycles preloaded to 0xFFFF, then a further load-use stall -> stays 0xFFFF; rst asserted in TRAP -> all outputs at reset values immediately.
